miner_nonce_ctrl: RTL

- Work dispatcher that sits directly upstream of the miner core.
- Accepts a 76-byte block-header prefix, a 256-bit target and a nonce range, then builds the 640-bit message for each nonce.
- For each nonce it pulses the core's hash_enable, waits for finished, and compares the returned byte-reversed double-SHA256 hash against the target.
- Reports the first winning nonce, range exhaustion, or a core timeout.

---
 rtl/miner_nonce_ctrl_if.sv | 41 ++++
 rtl/miner_nonce_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/miner_nonce_ctrl_if.sv
// Bundle between the nonce controller, its work source and the miner core.
// The controller uses the slave modport; work source plus core model use master.
interface miner_nonce_ctrl_if;
    localparam int unsigned HDR_W  = 608;
    localparam int unsigned MSG_W  = 640;
    localparam int unsigned HASH_W = 256;
    localparam int unsigned NONCE_W = 32;

    logic                 work_valid;
    logic                 work_ready;
    logic [0:HDR_W-1]     header_in;
    logic [0:HASH_W-1]    target_in;
    logic [NONCE_W-1:0]   nonce_start;
    logic [NONCE_W-1:0]   nonce_last;
    logic                 abort;
    logic                 hash_enable;
    logic [0:MSG_W-1]     message;
    logic                 finished;
    logic [0:HASH_W-1]    hash;
    logic                 found_valid;
    logic [NONCE_W-1:0]   found_nonce;
    logic [0:HASH_W-1]    found_hash;
    logic                 exhausted;
    logic                 timeout_err;
    logic                 busy;
    logic [NONCE_W-1:0]   hash_count;

    modport slave (
        input  work_valid, header_in, target_in, nonce_start, nonce_last, abort,
        input  finished, hash,
        output work_ready, hash_enable, message, found_valid, found_nonce, found_hash,
        output exhausted, timeout_err, busy, hash_count
    );

    modport master (
        output work_valid, header_in, target_in, nonce_start, nonce_last, abort,
        output finished, hash,
        input  work_ready, hash_enable, message, found_valid, found_nonce, found_hash,
        input  exhausted, timeout_err, busy, hash_count
    );
endinterface

// File: rtl/miner_nonce_ctrl.sv
// Nonce-range dispatcher for a double-SHA256 miner core: issues one nonce at a
// time, compares each returned hash with the target and reports win/exhaustion/timeout.
module miner_nonce_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    miner_nonce_ctrl_if.slave  bus
);
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned HASH_W  = 256;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t               state;
    logic [NONCE_W-1:0]   nonce_q;
    logic [NONCE_W-1:0]   nonce_last_q;
    logic [0:HASH_W-1]    target_q;
    logic [0:HASH_W-1]    hash_q;
    logic [WD_W-1:0]      wd;

    // Nonce is appended to the header little-endian, as the block header expects.
    function automatic logic [NONCE_W-1:0] le_bytes(input logic [NONCE_W-1:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            nonce_q         <= '0;
            nonce_last_q    <= '0;
            target_q        <= '0;
            hash_q          <= '0;
            wd              <= '0;
            bus.work_ready  <= 1'b1;
            bus.busy        <= 1'b0;
            bus.hash_enable <= 1'b0;
            bus.message     <= '0;
            bus.found_valid <= 1'b0;
            bus.found_nonce <= '0;
            bus.found_hash  <= '0;
            bus.exhausted   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.hash_count  <= '0;
        end else begin
            bus.hash_enable <= 1'b0;
            bus.found_valid <= 1'b0;
            bus.exhausted   <= 1'b0;
            bus.timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.work_valid) begin
                        bus.message[0:607]   <= bus.header_in;
                        bus.message[608:639] <= le_bytes(bus.nonce_start);
                        target_q        <= bus.target_in;
                        nonce_q         <= bus.nonce_start;
                        nonce_last_q    <= bus.nonce_last;
                        bus.hash_count  <= '0;
                        bus.found_nonce <= '0;
                        bus.found_hash  <= '0;
                        bus.hash_enable <= 1'b1;
                        bus.work_ready  <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= START;
                    end
                end

                START: begin
                    wd <= '0;
                    if (bus.abort) begin
                        bus.work_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.abort) begin
                        // A core that finishes in the abort cycle is already idle: no drain needed.
                        wd <= wd + WD_W'(1);
                        if (bus.finished) begin
                            bus.work_ready <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (bus.finished) begin
                        hash_q <= bus.hash;
                        if (bus.hash_count != '1) begin
                            bus.hash_count <= bus.hash_count + 32'd1;
                        end
                        state <= CHECK;
                    end else if (wd == WD_LAST) begin
                        bus.timeout_err <= 1'b1;
                        bus.work_ready  <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                CHECK: begin
                    if (bus.abort) begin
                        bus.work_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else if (hash_q <= target_q) begin
                        bus.found_valid <= 1'b1;
                        bus.found_nonce <= nonce_q;
                        bus.found_hash  <= hash_q;
                        bus.work_ready  <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (nonce_q == nonce_last_q) begin
                        bus.exhausted  <= 1'b1;
                        bus.work_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        nonce_q              <= nonce_q + 32'd1;
                        bus.message[608:639] <= le_bytes(nonce_q + 32'd1);
                        bus.hash_enable      <= 1'b1;
                        state                <= START;
                    end
                end

                DRAIN: begin
                    // Watchdog may already be past its limit if abort landed on the last WAIT cycle.
                    if (bus.finished || wd >= WD_LAST) begin
                        bus.work_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                default: begin
                    bus.work_ready <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule
